// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshakes and the data memory port of the
// load/store controller, bundled so the controller and its environment
// connect through a single port.
//   master : execute stage, writeback consumer and data memory (environment)
//   slave  : lsu_ctrl
interface lsu_ctrl_if;
    // execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // writeback response
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    // data memory port
    logic [31:0] Address;
    logic [31:0] write_data;
    logic        MemRead;
    logic        memWrite;
    logic [31:0] read_data;

    modport master (
        output req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, read_data,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  Address, write_data, MemRead, memWrite
    );

    modport slave (
        input  req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, read_data,
        output req_ready, resp_valid, resp_data, resp_err,
        output Address, write_data, MemRead, memWrite
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller in front of the data
// memory. Sequences MemRead/memWrite, merges sub-word stores with a
// read-modify-write, and returns aligned, extended load data.
//
// Build option: define LSU_SUBWORD_EN to enable byte/half accesses (lane
// extraction and the RMW path). Without it only aligned word accesses are
// served and any other size is answered with resp_err.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | req_ready=1, waiting for a request
// RD     | MemRead=1, load word captured at the end of the cycle
// RMW_RD | MemRead=1, old word merged with store lane (sub-word only)
// WR     | memWrite=1 with the full or merged word
// RESP   | resp_valid=1, held until resp_ready
//
// All outputs are registered and set together with the next state, so the
// strobes are a function of the registered state only.
module lsu_ctrl (
    input  logic       clk,
    input  logic       reset,
    lsu_ctrl_if.slave  bus
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSV   = 2'b11;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;

`ifdef LSU_SUBWORD_EN
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, WR, RESP} state_t;
`endif

    state_t      state;
    logic        req_err;

`ifdef LSU_SUBWORD_EN
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_lo_q;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] merge_data;
`endif

    // Request legality: reserved encodings and misaligned addresses.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_op == OP_RSV) req_err = 1'b1;
`ifdef LSU_SUBWORD_EN
        case (bus.req_size)
            SZ_BYTE: ;
            SZ_HALF: if (bus.req_addr[0]) req_err = 1'b1;
            SZ_WORD: if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
`else
        if (bus.req_size != SZ_WORD || bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    end

`ifdef LSU_SUBWORD_EN
    // Load lane extraction: shift the addressed lane to bit 0, then extend.
    always_comb begin
        shifted = bus.read_data >> {lane_q, 3'b000};
        case (size_q)
            SZ_BYTE: load_data = uns_q ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = uns_q ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = bus.read_data;
        endcase
    end

    // Store merge: replace the addressed byte or half of the word just read.
    always_comb begin
        merge_data = bus.read_data;
        if (size_q == SZ_BYTE)
            merge_data[{lane_q, 3'b000} +: 8] = wdata_lo_q[7:0];
        else
            merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_lo_q;
    end
`endif

    // Controller FSM with registered handshake and memory outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= 32'h0;
            bus.resp_err   <= 1'b0;
            bus.MemRead    <= 1'b0;
            bus.memWrite   <= 1'b0;
            bus.Address    <= 32'h0;
            bus.write_data <= 32'h0;
`ifdef LSU_SUBWORD_EN
            size_q         <= SZ_WORD;
            uns_q          <= 1'b0;
            lane_q         <= 2'b00;
            wdata_lo_q     <= 16'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
`ifdef LSU_SUBWORD_EN
                        size_q        <= bus.req_size;
                        uns_q         <= bus.req_unsigned;
                        lane_q        <= bus.req_addr[1:0];
                        wdata_lo_q    <= bus.req_wdata[15:0];
`endif
                        if (req_err) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_data  <= 32'h0;
                        end else begin
                            case (bus.req_op)
                                OP_LOAD: begin
                                    state       <= RD;
                                    bus.MemRead <= 1'b1;
                                    bus.Address <= {2'b00, bus.req_addr[31:2]};
                                end
                                OP_STORE: begin
                                    bus.Address <= {2'b00, bus.req_addr[31:2]};
`ifdef LSU_SUBWORD_EN
                                    if (bus.req_size == SZ_WORD) begin
                                        state          <= WR;
                                        bus.memWrite   <= 1'b1;
                                        bus.write_data <= bus.req_wdata;
                                    end else begin
                                        state       <= RMW_RD;
                                        bus.MemRead <= 1'b1;
                                    end
`else
                                    state          <= WR;
                                    bus.memWrite   <= 1'b1;
                                    bus.write_data <= bus.req_wdata;
`endif
                                end
                                default: begin
                                    state          <= RESP;
                                    bus.resp_valid <= 1'b1;
                                    bus.resp_err   <= 1'b0;
                                    bus.resp_data  <= 32'h0;
                                end
                            endcase
                        end
                    end
                end
                RD: begin
                    state          <= RESP;
                    bus.MemRead    <= 1'b0;
                    bus.Address    <= 32'h0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
`ifdef LSU_SUBWORD_EN
                    bus.resp_data  <= load_data;
`else
                    bus.resp_data  <= bus.read_data;
`endif
                end
`ifdef LSU_SUBWORD_EN
                RMW_RD: begin
                    state          <= WR;
                    bus.MemRead    <= 1'b0;
                    bus.memWrite   <= 1'b1;
                    bus.write_data <= merge_data;
                end
`endif
                WR: begin
                    state          <= RESP;
                    bus.memWrite   <= 1'b0;
                    bus.Address    <= 32'h0;
                    bus.write_data <= 32'h0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_data  <= 32'h0;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_data  <= 32'h0;
                        bus.resp_err   <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_data  <= 32'h0;
                    bus.resp_err   <= 1'b0;
                    bus.MemRead    <= 1'b0;
                    bus.memWrite   <= 1'b0;
                    bus.Address    <= 32'h0;
                    bus.write_data <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a word-addressed memory
// model, a reference memory, and a queue of predicted responses.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;

    always #5 clk = ~clk;

    lsu_ctrl_if bus ();

    lsu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    // Data memory: combinational read while MemRead, write on the clock edge.
    assign bus.read_data = bus.MemRead ? mem[bus.Address[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h80817F01;
        end else if (bus.memWrite) begin
            mem[bus.Address[5:0]] <= bus.write_data;
        end
    end

    // Strobe monitor, sampled mid-cycle.
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] rd_addr_last = 0, wr_addr_last = 0, wr_data_last = 0;

    always @(negedge clk) begin
        if (bus.MemRead) begin
            rd_cnt++;
            rd_addr_last = bus.Address;
        end
        if (bus.memWrite) begin
            wr_cnt++;
            wr_addr_last = bus.Address;
            wr_data_last = bus.write_data;
        end
        if (bus.MemRead && bus.memWrite) both_cnt++;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wdata;
        logic [31:0] waddr;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference behaviour of one request; updates the reference memory.
    task automatic predict(input logic [1:0] op, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        logic        err;
        logic [1:0]  n;
        logic [31:0] w, sh;
        n = addr[1:0];
        w = ref_mem[addr[7:2]];
`ifdef LSU_SUBWORD_EN
        err = (op == 2'b11) || (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && n != 2'b00);
`else
        err = (op == 2'b11) || (size != 2'b10) || (n != 2'b00);
`endif
        e.data = 32'h0; e.err = err; e.lat = 1; e.rd = 0; e.wr = 0;
        e.wdata = 32'h0; e.waddr = {2'b00, addr[31:2]};
        if (!err && op == 2'b01) begin
            e.lat = 2; e.rd = 1;
            sh = w >> (8 * n);
            case (size)
                2'b00:   e.data = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
                2'b01:   e.data = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                default: e.data = w;
            endcase
        end else if (!err && op == 2'b10) begin
            e.wr = 1;
            if (size == 2'b10) begin
                e.lat = 2;
                w = wdata;
            end else begin
                e.lat = 3; e.rd = 1;
                if (size == 2'b00) w[8 * n +: 8] = wdata[7:0];
                else               w[16 * n[1] +: 16] = wdata[15:0];
            end
            ref_mem[addr[7:2]] = w;
            e.wdata = w;
        end
    endtask

    // Drive one request, then check the response against the scoreboard.
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input string tag);
        exp_t e, got;
        int   rd0, wr0, lat, waitc;
        logic seen;
        logic [31:0] d0;
        logic        e0;
        predict(op, size, uns, addr, wdata, e);
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        if (hold > 0) bus.resp_ready = 1'b0;
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        #1 bus.req_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, " busy"}, 32'(bus.req_ready), 32'd0);
            seen = bus.resp_valid;
        end
        got = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(got.lat));
        if (seen) begin
            check({tag, " data"}, bus.resp_data, got.data);
            check({tag, " err"}, 32'(bus.resp_err), 32'(got.err));
            check({tag, " reads"}, 32'(rd_cnt - rd0), 32'(got.rd));
            check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(got.wr));
            if (got.rd > 0) check({tag, " rd_addr"}, rd_addr_last, got.waddr);
            if (got.wr > 0) begin
                check({tag, " wr_addr"}, wr_addr_last, got.waddr);
                check({tag, " wr_data"}, wr_data_last, got.wdata);
            end
            d0 = bus.resp_data;
            e0 = bus.resp_err;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, " stall valid"}, 32'(bus.resp_valid), 32'd1);
                check({tag, " stall data"}, bus.resp_data, d0);
                check({tag, " stall err"}, 32'(bus.resp_err), 32'(e0));
                check({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
            end
            if (hold > 0) begin
                check({tag, " stall strobes"}, 32'(rd_cnt - rd0 + wr_cnt - wr0),
                      32'(got.rd + got.wr));
                bus.resp_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            check({tag, " released"}, 32'(bus.resp_valid), 32'd0);
            check({tag, " idle"}, 32'(bus.req_ready), 32'd1);
        end else begin
            bus.resp_ready = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},  32'(bus.req_ready),  32'd1);
        check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " resp_data"},  bus.resp_data,       32'h0);
        check({tag, " resp_err"},   32'(bus.resp_err),   32'd0);
        check({tag, " MemRead"},    32'(bus.MemRead),    32'd0);
        check({tag, " memWrite"},   32'(bus.memWrite),   32'd0);
        check({tag, " Address"},    bus.Address,         32'h0);
        check({tag, " write_data"}, bus.write_data,      32'h0);
    endtask

    initial begin
        int wr0, rd0;
        reset            = 1'b1;
        mem_init         = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_op       = 2'b00;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_mem[4] = 32'h80817F01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        mem_init = 1'b0;
        check_reset_outputs("reset");

        issue(2'b01, 2'b00, 1'b0, 32'h13, 32'h0,        0, "lb_13");
        issue(2'b01, 2'b01, 1'b1, 32'h12, 32'h0,        0, "lhu_12");
        issue(2'b01, 2'b01, 1'b0, 32'h10, 32'h0,        0, "lh_10");
        issue(2'b01, 2'b00, 1'b1, 32'h13, 32'h0,        0, "lbu_13");
        issue(2'b01, 2'b00, 1'b0, 32'h11, 32'h0,        0, "lb_11");
        issue(2'b10, 2'b00, 1'b0, 32'h11, 32'hAB,       0, "sb_11");
        issue(2'b01, 2'b10, 1'b0, 32'h10, 32'h0,        0, "lw_10a");
        issue(2'b10, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 0, "sh_12");
        issue(2'b01, 2'b10, 1'b0, 32'h10, 32'h0,        0, "lw_10b");
        issue(2'b10, 2'b10, 1'b0, 32'h20, 32'h12345678, 0, "sw_20");
        issue(2'b01, 2'b10, 1'b0, 32'h20, 32'h0,        0, "lw_20");
        issue(2'b01, 2'b10, 1'b0, 32'h12, 32'h0,        0, "lw_mis");
        issue(2'b01, 2'b01, 1'b0, 32'h11, 32'h0,        0, "lh_mis");
        issue(2'b10, 2'b10, 1'b0, 32'h21, 32'h5,        0, "sw_mis");
        issue(2'b11, 2'b10, 1'b0, 32'h10, 32'h0,        0, "op_rsv");
        issue(2'b01, 2'b11, 1'b0, 32'h10, 32'h0,        0, "sz_rsv");
        issue(2'b00, 2'b10, 1'b0, 32'h0,  32'h0,        0, "nop");
        issue(2'b01, 2'b00, 1'b0, 32'h10, 32'h0,        0, "lb_10");
        issue(2'b01, 2'b10, 1'b0, 32'h10, 32'h0,        3, "lw_stall");

        // Reset in the cycle after accepting a byte store (RMW_RD when enabled).
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_op       = 2'b10;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h12;
        bus.req_wdata    = 32'hCD;
        @(posedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
`ifdef LSU_SUBWORD_EN
        check("rst_rmw MemRead", 32'(bus.MemRead), 32'd1);
`else
        check("rst_rmw resp_err", 32'(bus.resp_err), 32'd1);
`endif
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("rst_rmw");
        repeat (4) @(negedge clk);
        check("rst_rmw writes", 32'(wr_cnt - wr0), 32'd0);
        check("rst_rmw mem", mem[4], ref_mem[4]);
`ifdef LSU_SUBWORD_EN
        check("rst_rmw reads", 32'(rd_cnt - rd0), 32'd1);
`else
        check("rst_rmw reads", 32'(rd_cnt - rd0), 32'd0);
`endif

        issue(2'b01, 2'b10, 1'b0, 32'h10, 32'h0, 0, "lw_post");
        check("strobe overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting directly upstream of the data memory block (`MEM`) in the processor datapath. It accepts one memory request at a time from the execute stage over a valid/ready handshake. It sequences the memory's `MemRead`/`memWrite` strobes, performs read-modify-write for sub-word stores, and returns aligned, sign- or zero-extended load data to writeback over a second valid/ready handshake.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed)
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request
- `req_op`  in  2  00 nop, 01 load, 10 store, 11 reserved
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer takes response
- `resp_data`  out  32  extended load data; 0 for store/nop/error
- `resp_err`  out  1  misaligned or reserved request
- `Address`  out  32  word address to `MEM` = {2'b00, addr[31:2]}
- `write_data`  out  32  word to `MEM`
- `MemRead`  out  1  memory read strobe, active-high
- `memWrite`  out  1  memory write strobe, active-high
- `read_data`  in  32  word from `MEM`, valid combinationally in the cycle `MemRead`=1

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: `req_ready`=1. A request is accepted when `req_valid`&`req_ready`. The request fields are latched on acceptance.
- Request decode from IDLE:
  - load → RD.
  - word store → WR.
  - byte/half store → RMW_RD.
  - nop → RESP.
  - error → RESP with `resp_err`=1 and no memory strobe.
- Error conditions: reserved op or size; half with addr[0]=1; word with addr[1:0]≠0.
- RD: `MemRead`=1 for exactly one cycle. `read_data` is captured at the end of that cycle. Next state RESP.
- RMW_RD: `MemRead`=1 for one cycle. The captured word has the target lane replaced by the store data. Next state WR.
- WR: `memWrite`=1 for exactly one cycle, carrying the merged or full word. Next state RESP.
- RESP: `resp_valid`=1 with `resp_data` and `resp_err` held stable until `resp_ready`=1. Then → IDLE.
- Lanes are little-endian:
  - byte n occupies bits [8n+7:8n], n = addr[1:0];
  - the half at offset 0 is [15:0], the half at offset 2 is [31:16].
- Load extraction: the selected lane is shifted to bit 0, then extended from bit 7 or bit 15 according to `req_unsigned`. Word loads pass through unchanged.
- `MemRead` and `memWrite` are decoded from the registered state only. They are never both 1.
- `Address` and `write_data` are stable for the whole cycle of any strobe. They are 0 in IDLE and RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1 after reset, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `MemRead`=0, `memWrite`=0, `Address`=0, `write_data`=0.
- Latency from the acceptance edge to `resp_valid`:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - nop or error: 1 cycle.
- Throughput: no request is accepted outside IDLE. `req_ready`=0 from acceptance until the cycle after the response handshake.
- Response backpressure stalls the controller in RESP indefinitely. No memory strobe occurs while stalled.
- Reset asserted in the same cycle as a strobe: the strobe for that cycle still completes, since it is state-decoded. State is IDLE on the next edge. No further strobe follows and the pending response is discarded.
- Reset during RMW_RD: no `memWrite` is ever issued for that request.

## Configuration
- `LSU_SUBWORD_EN` defined: byte and half loads and stores are supported as above, including the RMW path.
- `LSU_SUBWORD_EN` undefined: the RMW_RD state and lane logic are removed. Any `req_size`≠10 returns `resp_err`=1 with no memory access.

## Test plan
- Preload word 4 = 0x80817F01. Signed byte load at 0x13 → `MemRead` for 1 cycle with `Address`=4; `resp_valid` 2 cycles after accept; `resp_data`=0xFFFFFF80.
- Same preload. Unsigned half load at 0x12 → `resp_data`=0x00008081, `resp_err`=0.
- Same preload. Byte store of 0xAB at 0x11 → one `MemRead` cycle, then one `memWrite` cycle with `write_data`=0x8081AB01; a word re-read returns 0x8081AB01.
- Word load at 0x12 → `resp_err`=1 one cycle after accept, `resp_data`=0, no strobes. With `LSU_SUBWORD_EN` undefined, a byte load at 0x10 → `resp_err`=1.
- Hold `resp_ready`=0 for 3 cycles after a load response → `resp_valid`, `resp_data` and `resp_err` stable; `req_ready`=0; no strobes; IDLE on release.
- Assert `reset` in the RMW_RD cycle of a byte store → no `memWrite` is issued; the next cycle shows all outputs at reset values with `req_ready`=1.
